// File: rtl/fp_pkg.sv
// Shared widths and FSM state encoding for the FP adder mantissa datapath.
package fp_pkg;

    localparam int MANT_W  = 24;
    localparam int EXP_W   = 8;
    localparam int SHIFT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mant_abs_sub.sv
// Combinational magnitude subtractor: the larger operand is always the
// minuend, so the N-bit difference never borrows.
module mant_abs_sub
    import fp_pkg::*;
#(
    parameter int N = MANT_W
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         swap,
    output logic         is_zero
);

    logic a_ge_b_s;

    // Select minuend/subtrahend by magnitude and flag exact cancellation
    always_comb begin
        a_ge_b_s = (a >= b);
        if (a_ge_b_s) begin
            diff = a - b;
        end else begin
            diff = b - a;
        end
        swap    = ~a_ge_b_s;
        is_zero = (a == b);
    end

endmodule

// File: rtl/fp_mant_sub_norm.sv
// Multi-cycle mantissa subtract-and-normalise: |a-b| then one left shift per
// cycle, decrementing the exponent, until the MSB is set or the exponent hits 0.
module fp_mant_sub_norm
    import fp_pkg::*;
#(
    parameter int N  = MANT_W,
    parameter int E  = EXP_W,
    parameter int SW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a_mant,
    input  logic [N-1:0]  b_mant,
    input  logic [E-1:0]  exp_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  diff_mant,
    output logic [E-1:0]  exp_out,
    output logic          swap,
    output logic          zero,
    output logic [SW-1:0] norm_shift
);

    state_t        state_r, state_s;
    logic          load_s;
    logic [N-1:0]  a_r, b_r;
    logic [E-1:0]  exp_in_r;
    logic          in_ready_r, out_valid_r;
    logic [N-1:0]  diff_r, diff_s;
    logic [E-1:0]  exp_r, exp_s;
    logic          swap_r, swap_s;
    logic          zero_r, zero_s;
    logic [SW-1:0] shift_r, shift_s;

    logic [N-1:0]  abs_diff_s;
    logic          abs_swap_s;
    logic          abs_zero_s;

    mant_abs_sub #(.N(N)) u_abs_sub (
        .a       (a_r),
        .b       (b_r),
        .diff    (abs_diff_s),
        .swap    (abs_swap_s),
        .is_zero (abs_zero_s)
    );

    // Next-state and next-result computation; diff/exp registers double as
    // the working normalisation state while in NORM
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        diff_s  = diff_r;
        exp_s   = exp_r;
        swap_s  = swap_r;
        zero_s  = zero_r;
        shift_s = shift_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    load_s  = 1'b1;
                    state_s = SUB;
                end else begin
                    state_s = IDLE;
                end
            end
            SUB: begin
                diff_s  = abs_diff_s;
                swap_s  = abs_swap_s;
                zero_s  = abs_zero_s;
                shift_s = {SW{1'b0}};
                if (abs_zero_s) begin
                    exp_s   = {E{1'b0}};
                    state_s = DONE;
                end else if (abs_diff_s[N-1] || (exp_in_r == {E{1'b0}})) begin
                    exp_s   = exp_in_r;
                    state_s = DONE;
                end else begin
                    exp_s   = exp_in_r;
                    state_s = NORM;
                end
            end
            NORM: begin
                // Entry guarantees exp_r != 0, so the decrement cannot wrap
                diff_s  = {diff_r[N-2:0], 1'b0};
                exp_s   = exp_r - {{(E-1){1'b0}}, 1'b1};
                shift_s = shift_r + {{(SW-1){1'b0}}, 1'b1};
                if (diff_s[N-1] || (exp_s == {E{1'b0}})) begin
                    state_s = DONE;
                end else begin
                    state_s = NORM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, operand capture and registered result/handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= {N{1'b0}};
            b_r         <= {N{1'b0}};
            exp_in_r    <= {E{1'b0}};
            diff_r      <= {N{1'b0}};
            exp_r       <= {E{1'b0}};
            swap_r      <= 1'b0;
            zero_r      <= 1'b0;
            shift_r     <= {SW{1'b0}};
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            if (load_s) begin
                a_r      <= a_mant;
                b_r      <= b_mant;
                exp_in_r <= exp_in;
            end
            diff_r      <= diff_s;
            exp_r       <= exp_s;
            swap_r      <= swap_s;
            zero_r      <= zero_s;
            shift_r     <= shift_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign diff_mant  = diff_r;
    assign exp_out    = exp_r;
    assign swap       = swap_r;
    assign zero       = zero_r;
    assign norm_shift = shift_r;

endmodule

// File: tb/tb_fp_mant_sub_norm.sv
// Directed bench for fp_mant_sub_norm with an arithmetic reference model and
// a per-cycle output compare process.
module tb_fp_mant_sub_norm;

    localparam int N  = 24;
    localparam int E  = 8;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a_mant, b_mant;
    logic [E-1:0]  exp_in;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  diff_mant;
    logic [E-1:0]  exp_out;
    logic          swap, zero;
    logic [SW-1:0] norm_shift;

    fp_mant_sub_norm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_mant     (a_mant),
        .b_mant     (b_mant),
        .exp_in     (exp_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff_mant  (diff_mant),
        .exp_out    (exp_out),
        .swap       (swap),
        .zero       (zero),
        .norm_shift (norm_shift)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] diff;
        logic [E-1:0] expo;
        logic         swap;
        logic         zero;
        int           shift;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic first_seen = 1'b0;
    logic post_hs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: magnitude difference, then shift left while MSB clear and exponent positive
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic [E-1:0] e);
        exp_t r;
        logic [N-1:0] d;
        int ex;
        int k;
        r.swap = (b > a);
        d = r.swap ? (b - a) : (a - b);
        r.zero = (d == 0);
        ex = int'(e);
        k = 0;
        if (r.zero) begin
            ex = 0;
        end else begin
            while (d[N-1] == 1'b0 && ex > 0) begin
                d = d << 1;
                ex = ex - 1;
                k = k + 1;
            end
        end
        r.diff  = d;
        r.expo  = ex[E-1:0];
        r.shift = k;
        r.acc   = 0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Output compare: sampled 1 time unit after the falling edge
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            first_seen = 1'b0;
            post_hs    = 1'b0;
        end else begin
            if (post_hs) begin
                check("in_ready_after_hs", 32'(in_ready), 32'd1);
                check("out_valid_after_hs", 32'(out_valid), 32'd0);
                post_hs = 1'b0;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (t=%0t)", $time);
                end else begin
                    cur = exp_q[0];
                    if (!first_seen) begin
                        check("latency", 32'(cyc - cur.acc), 32'(cur.shift + 2));
                        first_seen = 1'b1;
                    end
                    check("diff_mant", 32'(diff_mant), 32'(cur.diff));
                    check("exp_out", 32'(exp_out), 32'(cur.expo));
                    check("swap", 32'(swap), 32'(cur.swap));
                    check("zero", 32'(zero), 32'(cur.zero));
                    check("norm_shift", 32'(norm_shift), 32'(cur.shift));
                    check("in_ready_busy", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        first_seen = 1'b0;
                        post_hs    = 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_case(input logic [N-1:0] a, input logic [N-1:0] b, input logic [E-1:0] e);
        exp_t m;
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            m = model(a, b, e);
            m.acc = cyc;
            exp_q.push_back(m);
            in_valid = 1'b1;
            a_mant   = a;
            b_mant   = b;
            exp_in   = e;
            @(negedge clk);
            in_valid = 1'b0;
            a_mant   = 24'($urandom);
            b_mant   = 24'($urandom);
            exp_in   = 8'($urandom);
        end
    endtask

    task automatic wait_drain(input int max);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < max) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_diff"}, 32'(diff_mant), 32'd0);
        check({tag, "_exp"}, 32'(exp_out), 32'd0);
        check({tag, "_swap"}, 32'(swap), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd0);
        check({tag, "_shift"}, 32'(norm_shift), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t m;
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_mant    = 24'h000000;
        b_mant    = 24'h000000;
        exp_in    = 8'd0;

        // Pin the model with hand-computed values
        m = model(24'h800005, 24'h000003, 8'd100);
        check("model1_diff", 32'(m.diff), 32'h800002);
        check("model1_shift", 32'(m.shift), 32'd0);
        m = model(24'h000003, 24'h800000, 8'd100);
        check("model2_diff", 32'(m.diff), 32'hFFFFFA);
        check("model2_exp", 32'(m.expo), 32'd99);
        check("model2_swap", 32'(m.swap), 32'd1);
        m = model(24'h000005, 24'h000003, 8'd10);
        check("model4_diff", 32'(m.diff), 32'h000800);
        check("model4_shift", 32'(m.shift), 32'd10);
        m = model(24'hFFFFFF, 24'hFFFFFF, 8'd50);
        check("model3_zero", 32'(m.zero), 32'd1);
        check("model3_exp", 32'(m.expo), 32'd0);

        @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_case(24'h800005, 24'h000003, 8'd100);
        wait_drain(50);
        do_case(24'h000003, 24'h800000, 8'd100);
        wait_drain(50);
        do_case(24'hFFFFFF, 24'hFFFFFF, 8'd50);
        wait_drain(50);
        do_case(24'h000005, 24'h000003, 8'd10);
        wait_drain(50);
        do_case(24'h000001, 24'h000000, 8'd200);
        wait_drain(60);
        do_case(24'h000100, 24'h000080, 8'd0);
        wait_drain(50);
        do_case(24'h400000, 24'h000000, 8'd1);
        wait_drain(50);
        do_case(24'h123456, 24'h123457, 8'd30);
        wait_drain(60);

        // Stalled consumer: result must be held while out_ready is low
        out_ready = 1'b0;
        do_case(24'hC00000, 24'h400001, 8'd127);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("stall_out_valid_seen", 32'(out_valid), 32'd1);
        repeat (5) @(negedge clk);
        #1;
        check("stall_diff_held", 32'(diff_mant), 32'hFFFFFE);
        check("stall_exp_held", 32'(exp_out), 32'd126);
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain(20);

        // Asynchronous reset in the middle of normalisation
        do_case(24'h000005, 24'h000003, 8'd10);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        do_case(24'h800005, 24'h000003, 8'd100);
        wait_drain(50);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
